// File: rtl/ddr3_read_pkg.sv
// Shared types and size derivations for the DDR3 frame read scheduler.
package ddr3_read_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN
  } state_e;

  typedef logic [1:0] third_t;

  localparam int BEAT_CNT_W = 15;

  // A DDR3 word is 256 bits, so one strip line spans width*bits/256 words.
  function automatic int calc_third_stride(input int third_width, input int pix_width);
    return third_width * pix_width / 256;
  endfunction

  function automatic int calc_beats_per_frame(input int lines, input int stride);
    return 3 * lines * stride;
  endfunction

endpackage

// File: rtl/ddr3_read_scheduler.sv
// Schedules one frame read as three strip commands to the gray-filter reader
// and tracks returning beats to know when the frame buffer can be released.
module ddr3_read_scheduler
  import ddr3_read_pkg::*;
#(
  parameter int in_width          = 16,
  parameter int frame_third_width = 240,
  parameter int frame_lines       = 480
) (
  input  logic        ddr3clk,
  input  logic        ddr3clk_reset,
  input  logic        enable,
  input  logic        frame_wr_done,
  input  logic [26:0] frame_wr_base,
  output logic [28:0] start_data,
  output logic        start_valid,
  input  logic        start_ready,
  input  logic        ddr3_readdatavalid,
  output logic        frame_rd_done,
  output logic [26:0] frame_rd_base,
  output logic        busy,
  output logic [7:0]  frames_dropped,
  output logic        beat_overflow
);

  localparam int THIRD_STRIDE    = calc_third_stride(frame_third_width, in_width);
  localparam int BEATS_PER_FRAME = calc_beats_per_frame(frame_lines, THIRD_STRIDE);
  localparam logic [BEAT_CNT_W-1:0] BEATS_LAST = BEAT_CNT_W'(BEATS_PER_FRAME);

  state_e                  state_q, state_d;
  third_t                  third_q, third_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [26:0]             pending_base_q, pending_base_d;
  logic [26:0]             rd_base_q, rd_base_d;
  logic                    start_valid_q, start_valid_d;
  logic [28:0]             start_data_q, start_data_d;
  logic                    rd_done_q, rd_done_d;
  logic [7:0]              dropped_q, dropped_d;
  logic                    overflow_q, overflow_d;
  logic                    consume;

  function automatic logic [28:0] cmd_word(input third_t t, input logic [26:0] base);
    return {t, base + 27'(t) * 27'(THIRD_STRIDE)};
  endfunction

  always_comb begin
    state_d         = state_q;
    third_d         = third_q;
    beat_cnt_d      = beat_cnt_q;
    pending_valid_d = pending_valid_q;
    pending_base_d  = pending_base_q;
    rd_base_d       = rd_base_q;
    start_valid_d   = start_valid_q;
    start_data_d    = start_data_q;
    rd_done_d       = 1'b0;
    dropped_d       = dropped_q;
    overflow_d      = overflow_q;
    consume         = 1'b0;

    // Beats with no frame in flight mean the reader and scheduler disagree.
    if (ddr3_readdatavalid) begin
      if (state_q == S_IDLE) overflow_d = 1'b1;
      else                   beat_cnt_d = beat_cnt_q + 15'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (enable && pending_valid_q) begin
          consume       = 1'b1;
          rd_base_d     = pending_base_q;
          third_d       = 2'd0;
          beat_cnt_d    = '0;
          start_valid_d = 1'b1;
          start_data_d  = cmd_word(2'd0, pending_base_q);
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (start_ready) begin
          start_valid_d = 1'b0;
          state_d       = (third_q < 2'd2) ? S_GAP : S_DRAIN;
        end
      end
      S_GAP: begin
        third_d       = third_q + 2'd1;
        start_valid_d = 1'b1;
        start_data_d  = cmd_word(third_q + 2'd1, rd_base_q);
        state_d       = S_ISSUE;
      end
      S_DRAIN: begin
        if (beat_cnt_q >= BEATS_LAST) begin
          rd_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new frame replaces an unread one; a same-cycle hand-off is not a drop.
    if (frame_wr_done) begin
      pending_base_d  = frame_wr_base;
      pending_valid_d = 1'b1;
      if (pending_valid_q && !consume && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
    end else if (consume) begin
      pending_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ddr3clk) begin
    if (ddr3clk_reset) begin
      state_q         <= S_IDLE;
      third_q         <= 2'd0;
      beat_cnt_q      <= '0;
      pending_valid_q <= 1'b0;
      pending_base_q  <= '0;
      rd_base_q       <= '0;
      start_valid_q   <= 1'b0;
      start_data_q    <= '0;
      rd_done_q       <= 1'b0;
      dropped_q       <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      third_q         <= third_d;
      beat_cnt_q      <= beat_cnt_d;
      pending_valid_q <= pending_valid_d;
      pending_base_q  <= pending_base_d;
      rd_base_q       <= rd_base_d;
      start_valid_q   <= start_valid_d;
      start_data_q    <= start_data_d;
      rd_done_q       <= rd_done_d;
      dropped_q       <= dropped_d;
      overflow_q      <= overflow_d;
    end
  end

  assign start_valid    = start_valid_q;
  assign start_data     = start_data_q;
  assign frame_rd_done  = rd_done_q;
  assign frame_rd_base  = rd_base_q;
  assign busy           = (state_q != S_IDLE);
  assign frames_dropped = dropped_q;
  assign beat_overflow  = overflow_q;

endmodule

// File: tb/tb_ddr3_read_scheduler.sv
// Directed bench for ddr3_read_scheduler: command sequencing, pending slot, drain and reset.
module tb_ddr3_read_scheduler;

  localparam int STRIDE = 15;
  localparam int BPF    = 21600;

  logic        ddr3clk;
  logic        ddr3clk_reset;
  logic        enable;
  logic        frame_wr_done;
  logic [26:0] frame_wr_base;
  logic [28:0] start_data;
  logic        start_valid;
  logic        start_ready;
  logic        ddr3_readdatavalid;
  logic        frame_rd_done;
  logic [26:0] frame_rd_base;
  logic        busy;
  logic [7:0]  frames_dropped;
  logic        beat_overflow;

  int checks = 0;
  int errors = 0;
  bit seen;

  ddr3_read_scheduler dut (
    .ddr3clk            (ddr3clk),
    .ddr3clk_reset      (ddr3clk_reset),
    .enable             (enable),
    .frame_wr_done      (frame_wr_done),
    .frame_wr_base      (frame_wr_base),
    .start_data         (start_data),
    .start_valid        (start_valid),
    .start_ready        (start_ready),
    .ddr3_readdatavalid (ddr3_readdatavalid),
    .frame_rd_done      (frame_rd_done),
    .frame_rd_base      (frame_rd_base),
    .busy               (busy),
    .frames_dropped     (frames_dropped),
    .beat_overflow      (beat_overflow)
  );

  initial ddr3clk = 1'b0;
  always #5 ddr3clk = ~ddr3clk;

  typedef struct {
    logic        wr_done;
    logic [26:0] wr_base;
    logic        ready;
    logic        rdv;
    logic        exp_sv;
    logic [28:0] exp_sd;
    logic        exp_busy;
    logic [26:0] exp_rdbase;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ddr3clk);
    #1;
  endtask

  task automatic pulse_wr(input logic [26:0] b);
    frame_wr_done = 1'b1;
    frame_wr_base = b;
    tick();
    frame_wr_done = 1'b0;
  endtask

  task automatic send_beats(input int n);
    int early;
    early = 0;
    for (int k = 0; k < n; k++) begin
      ddr3_readdatavalid = 1'b1;
      tick();
      if (frame_rd_done) early++;
    end
    ddr3_readdatavalid = 1'b0;
    chk("no_early_done", early, 0);
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      tick();
      if (frame_rd_done) got = 1'b1;
    end
  endtask

  // Reader model: accepts each command, optionally after a stall.
  task automatic read_cmds(input logic [26:0] base, input int ncmds, input int stall);
    int          w;
    bit          stable;
    logic [1:0]  ti;
    logic [26:0] addr;
    logic [28:0] exp;
    for (int t = 0; t < ncmds; t++) begin
      w = 0;
      while (!start_valid && w < 20) begin
        tick();
        w++;
      end
      ti   = 2'(t);
      addr = base + 27'(t * STRIDE);
      exp  = {ti, addr};
      chk($sformatf("cmd%0d_valid", t), 32'(start_valid), 1);
      chk($sformatf("cmd%0d_data", t), 32'(start_data), 32'(exp));
      stable = 1'b1;
      for (int k = 0; k < stall; k++) begin
        tick();
        if (!start_valid || start_data !== exp) stable = 1'b0;
      end
      if (stall > 0) chk($sformatf("cmd%0d_stall_stable", t), 32'(stable), 1);
      start_ready = 1'b1;
      tick();
      start_ready = 1'b0;
      chk($sformatf("cmd%0d_valid_drop", t), 32'(start_valid), 0);
      if (t < 2) begin
        tick();
        chk($sformatf("cmd%0d_one_cycle_gap", t), 32'(start_valid), 1);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_valid"}, 32'(start_valid), 0);
    chk({tag, "_start_data"}, 32'(start_data), 0);
    chk({tag, "_rd_done"}, 32'(frame_rd_done), 0);
    chk({tag, "_rd_base"}, 32'(frame_rd_base), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_dropped"}, 32'(frames_dropped), 0);
  endtask

  initial begin
    bit quiet;

    vecs[0]  = '{1'b1, 27'h1000, 1'b0, 1'b0, 1'b0, 29'h0,        1'b0, 27'h0};
    vecs[1]  = '{1'b0, 27'h0,    1'b0, 1'b0, 1'b1, 29'h0001000,  1'b1, 27'h1000};
    vecs[2]  = '{1'b0, 27'h0,    1'b0, 1'b1, 1'b1, 29'h0001000,  1'b1, 27'h1000};
    vecs[3]  = '{1'b0, 27'h0,    1'b1, 1'b1, 1'b0, 29'h0,        1'b1, 27'h1000};
    vecs[4]  = '{1'b0, 27'h0,    1'b0, 1'b1, 1'b1, 29'h800100F,  1'b1, 27'h1000};
    vecs[5]  = '{1'b0, 27'h0,    1'b0, 1'b1, 1'b1, 29'h800100F,  1'b1, 27'h1000};
    vecs[6]  = '{1'b0, 27'h0,    1'b1, 1'b1, 1'b0, 29'h0,        1'b1, 27'h1000};
    vecs[7]  = '{1'b0, 27'h0,    1'b0, 1'b1, 1'b1, 29'h1000101E, 1'b1, 27'h1000};
    vecs[8]  = '{1'b0, 27'h0,    1'b0, 1'b1, 1'b1, 29'h1000101E, 1'b1, 27'h1000};
    vecs[9]  = '{1'b0, 27'h0,    1'b1, 1'b1, 1'b0, 29'h0,        1'b1, 27'h1000};
    vecs[10] = '{1'b0, 27'h0,    1'b0, 1'b1, 1'b0, 29'h0,        1'b1, 27'h1000};

    ddr3clk_reset      = 1'b1;
    enable             = 1'b1;
    frame_wr_done      = 1'b0;
    frame_wr_base      = '0;
    start_ready        = 1'b0;
    ddr3_readdatavalid = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    chk("reset_overflow", 32'(beat_overflow), 0);
    ddr3clk_reset = 1'b0;

    // First frame: load, three commands with one idle cycle between each
    for (int i = 0; i < 11; i++) begin
      frame_wr_done      = vecs[i].wr_done;
      frame_wr_base      = vecs[i].wr_base;
      start_ready        = vecs[i].ready;
      ddr3_readdatavalid = vecs[i].rdv;
      tick();
      chk($sformatf("vec%0d_start_valid", i), 32'(start_valid), 32'(vecs[i].exp_sv));
      if (vecs[i].exp_sv) chk($sformatf("vec%0d_start_data", i), 32'(start_data), 32'(vecs[i].exp_sd));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_rd_base", i), 32'(frame_rd_base), 32'(vecs[i].exp_rdbase));
      chk($sformatf("vec%0d_rd_done", i), 32'(frame_rd_done), 0);
    end
    frame_wr_done      = 1'b0;
    start_ready        = 1'b0;
    ddr3_readdatavalid = 1'b0;

    // Two writes while draining: the first is overwritten and counted
    send_beats(100);
    pulse_wr(27'h2000);
    chk("drop_after_first", 32'(frames_dropped), 0);
    pulse_wr(27'h3000);
    chk("drop_after_second", 32'(frames_dropped), 1);
    send_beats(BPF - 9 - 100);
    wait_done(5, seen);
    chk("frame1_done_seen", 32'(seen), 1);
    chk("frame1_done_base", 32'(frame_rd_base), 32'h1000);
    chk("frame1_no_overflow", 32'(beat_overflow), 0);
    chk("frame1_idle", 32'(busy), 0);

    // New write in the very cycle the idle state takes the pending frame
    frame_wr_done = 1'b1;
    frame_wr_base = 27'h4000;
    tick();
    frame_wr_done = 1'b0;
    chk("done_one_cycle", 32'(frame_rd_done), 0);
    chk("sameclk_no_drop", 32'(frames_dropped), 1);
    chk("frame2_base", 32'(frame_rd_base), 32'h3000);
    read_cmds(27'h3000, 3, 50);

    // Enable dropped mid-drain: frame finishes, pending one waits
    enable = 1'b0;
    send_beats(BPF);
    wait_done(5, seen);
    chk("frame2_done_seen", 32'(seen), 1);
    chk("frame2_done_base", 32'(frame_rd_base), 32'h3000);
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy || start_valid) quiet = 1'b0;
    end
    chk("disabled_stays_idle", 32'(quiet), 1);
    enable = 1'b1;
    tick();
    chk("frame3_starts", 32'(busy), 1);
    chk("frame3_base", 32'(frame_rd_base), 32'h4000);
    read_cmds(27'h4000, 2, 0);

    // Reset mid-frame, then a stray beat while idle
    ddr3clk_reset = 1'b1;
    tick();
    ddr3clk_reset = 1'b0;
    chk_reset_outputs("midreset");
    chk("midreset_overflow", 32'(beat_overflow), 0);
    ddr3_readdatavalid = 1'b1;
    tick();
    ddr3_readdatavalid = 1'b0;
    chk("stray_overflow", 32'(beat_overflow), 1);
    chk("stray_busy", 32'(busy), 0);
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (frame_rd_done || start_valid) quiet = 1'b0;
    end
    chk("abandoned_no_done", 32'(quiet), 1);
    chk("overflow_sticky", 32'(beat_overflow), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
